if_stage: RTL

- Instruction fetch stage directly upstream of the decode stage.
- Generates the fetch PC and issues requests on a pipelined instruction bus.
- Buffers returned words in a small prefetch FIFO and presents one registered {inst, inst_addr} pair per cycle to decode.
- Handles pipeline hold and jump redirect, discarding in-flight responses after a redirect.

---
 rtl/if_stage_pkg.sv | 36 +++
 rtl/if_fifo.sv | 79 +++++++
 rtl/if_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and types for the instruction fetch stage.
// Carries the core-wide bus macros (`INST_BUS, `INST_ADDR_BUS, `INST_NOP) and
// `IF_RESET_PC, the default fetch address after reset. Also provides the
// prefetch entry layout {pc, inst} and a word-alignment helper.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define INST_BUS      31:0
`define INST_ADDR_BUS 31:0
`define INST_NOP      32'h0000_0013
`define IF_RESET_PC   32'h0000_0000
`endif

package if_stage_pkg;

  typedef logic [`INST_BUS]      inst_t;
  typedef logic [`INST_ADDR_BUS] addr_t;

  localparam int unsigned InstW     = $bits(inst_t);
  localparam int unsigned AddrW     = $bits(addr_t);
  localparam inst_t       InstNop   = `INST_NOP;
  localparam addr_t       IfResetPc = `IF_RESET_PC;

  // One prefetch FIFO entry: the PC travels with its instruction word.
  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  localparam int unsigned EntryW = $bits(fetch_entry_t);

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic addr_t align_word(input addr_t addr);
    return {addr[AddrW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous prefetch FIFO for the fetch stage.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   flush        drop all entries (takes priority over push/pop)
//   push, din    write one entry at the tail
//   pop, dout    remove the head entry; dout always shows the head
//   count, empty current occupancy
// DEPTH must be a power of two, at least 2.
module if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  // Upstream credit accounting must never let a push meet a full FIFO.
  push_not_full_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (32'(count_q) == DEPTH)))
    else $error("if_fifo: push into full FIFO");

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage feeding decode.
// Issues word-aligned requests on a pipelined instruction bus, buffers the
// in-order responses in a prefetch FIFO and presents one registered
// {inst, inst_addr} pair per cycle to decode.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   hold_i                     downstream stall: keep outputs, do not pop
//   jump_flag_i, jump_addr_i   redirect; low two address bits ignored
//   ibus_req_o, ibus_addr_o    fetch request and address
//   ibus_gnt_i                 request accepted (only counts with req)
//   ibus_rvalid_i, ibus_rdata_i in-order response
//   inst_o, inst_addr_o        instruction and its PC to decode
//   inst_valid_o               inst_o is a real fetched instruction
// Build option: define IF_STAGE_BYPASS_EN to write a response straight into
// the output register when the FIFO is empty (1-edge rvalid-to-decode).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = IfResetPc,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             jump_flag_i,
  input  logic [AddrW-1:0] jump_addr_i,
  output logic             ibus_req_o,
  output logic [AddrW-1:0] ibus_addr_o,
  input  logic             ibus_gnt_i,
  input  logic             ibus_rvalid_i,
  input  logic [InstW-1:0] ibus_rdata_i,
  output logic [InstW-1:0] inst_o,
  output logic [AddrW-1:0] inst_addr_o,
  output logic             inst_valid_o
);

  // MAX_OUTSTANDING is at most 3; discard never exceeds outstanding.
  localparam int unsigned CntW     = 2;
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  logic [AddrW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AddrW-1:0]    resp_pc_q, resp_pc_d;
  logic [CntW-1:0]     outstanding_q, outstanding_d;
  logic [CntW-1:0]     discard_q, discard_d;
  logic [InstW-1:0]    inst_q, inst_d;
  logic [AddrW-1:0]    inst_addr_q, inst_addr_d;
  logic                inst_valid_q, inst_valid_d;

  logic [AddrW-1:0]    jump_pc;
  logic                grant;
  logic                accept;
  logic                bypass;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic [FifoCntW-1:0] fifo_count;
  fetch_entry_t        fifo_din;
  fetch_entry_t        fifo_dout;

  assign jump_pc = align_word(jump_addr_i);

  // Credit check: every in-flight request already owns a FIFO slot, so a
  // push can never find the FIFO full.
  always_comb begin
    ibus_req_o  = !rst && !jump_flag_i
                  && (32'(outstanding_q) < MAX_OUTSTANDING)
                  && ((32'(fifo_count) + 32'(outstanding_q)) < FIFO_DEPTH);
    ibus_addr_o = fetch_pc_q;
  end

  assign grant  = ibus_req_o & ibus_gnt_i;
  // A response is kept only if it is not stale and no redirect is happening.
  assign accept = ibus_rvalid_i & !jump_flag_i & (discard_q == '0);

`ifdef IF_STAGE_BYPASS_EN
  assign bypass = accept & fifo_empty & !hold_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = accept & !bypass;
  assign fifo_pop  = !jump_flag_i & !hold_i & !fifo_empty;

  always_comb begin
    fifo_din      = '0;
    fifo_din.pc   = resp_pc_q;
    fifo_din.inst = ibus_rdata_i;
  end

  // Credit, discard and PC bookkeeping.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({grant, ibus_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // On a redirect every response still in flight is stale. The post-update
    // outstanding count already includes responses an earlier jump marked
    // for discard, so it replaces rather than adds to the old discard count.
    discard_d = discard_q;
    if (jump_flag_i) begin
      discard_d = outstanding_d;
    end else if (ibus_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CntW'(1);
    end

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (jump_flag_i) begin
      fetch_pc_d = jump_pc;
      resp_pc_d  = jump_pc;
    end else begin
      if (grant)  fetch_pc_d = fetch_pc_q + AddrW'(4);
      if (accept) resp_pc_d  = resp_pc_q + AddrW'(4);
    end
  end

  // Output register toward decode. Jump wins over hold.
  always_comb begin
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
    if (jump_flag_i) begin
      inst_d       = InstNop;
      inst_addr_d  = jump_pc;
      inst_valid_d = 1'b0;
    end else if (!hold_i) begin
      if (!fifo_empty) begin
        inst_d       = fifo_dout.inst;
        inst_addr_d  = fifo_dout.pc;
        inst_valid_d = 1'b1;
      end else if (bypass) begin
        inst_d       = ibus_rdata_i;
        inst_addr_d  = resp_pc_q;
        inst_valid_d = 1'b1;
      end else begin
        // Bubble: the PC of the last delivered instruction is kept.
        inst_d       = InstNop;
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      inst_q        <= InstNop;
      inst_addr_q   <= RESET_PC;
      inst_valid_q  <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      inst_q        <= inst_d;
      inst_addr_q   <= inst_addr_d;
      inst_valid_q  <= inst_valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;

  if_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_if_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_flag_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
